// File: rtl/lsu_mem_arbiter_pkg.sv
// rtl/lsu_mem_arbiter_pkg.sv - shared types for the lsu/MMU data-port arbiter
package lsu_mem_arbiter_pkg;

  // One muxed memory request as presented to the MMU
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } mem_req_t;

  // Outstanding-request tag: owner port and "answer silently" marker
  typedef struct packed {
    logic drop;
    logic id;
  } arb_entry_t;

endpackage

// File: rtl/lsu_mem_arbiter_if.sv
// rtl/lsu_mem_arbiter_if.sv - lsu-side and MMU-side request/response bundle
interface lsu_mem_arbiter_if;
  logic [1:0]       rq_req;
  logic [1:0][31:0] rq_addr;
  logic [1:0]       rq_we;
  logic [1:0][1:0]  rq_size;
  logic [1:0][3:0]  rq_wstrb;
  logic [1:0][31:0] rq_wdata;
  logic [1:0]       rq_addr_ok;
  logic [1:0]       rq_data_ok;
  logic [31:0]      rq_rdata;

  logic             mmu_req;
  logic [31:0]      mmu_addr;
  logic             mmu_we;
  logic [1:0]       mmu_size;
  logic [3:0]       mmu_wstrb;
  logic [31:0]      mmu_wdata;
  logic             mmu_addr_ok;
  logic             mmu_data_ok;
  logic [31:0]      mmu_rdata;

  // Arbiter view: takes lsu requests, drives the MMU
  modport slave (
    input  rq_req, rq_addr, rq_we, rq_size, rq_wstrb, rq_wdata,
    output rq_addr_ok, rq_data_ok, rq_rdata,
    output mmu_req, mmu_addr, mmu_we, mmu_size, mmu_wstrb, mmu_wdata,
    input  mmu_addr_ok, mmu_data_ok, mmu_rdata
  );

  // Environment view: lsu lanes plus MMU model
  modport master (
    output rq_req, rq_addr, rq_we, rq_size, rq_wstrb, rq_wdata,
    input  rq_addr_ok, rq_data_ok, rq_rdata,
    input  mmu_req, mmu_addr, mmu_we, mmu_size, mmu_wstrb, mmu_wdata,
    output mmu_addr_ok, mmu_data_ok, mmu_rdata
  );
endinterface

// File: rtl/lsu_mem_arbiter_id_fifo.sv
// rtl/lsu_mem_arbiter_id_fifo.sv - in-order owner-ID FIFO with flush-marking
module lsu_mem_arbiter_id_fifo
  import lsu_mem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_push,
  input  logic       i_push_id,
  input  logic       i_pop,
  input  logic       i_flush,
  output logic       o_full,
  output logic       o_empty,
  output arb_entry_t o_head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);

  arb_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == C_DEPTH);
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rd];
  // Full blocks pushes even when a pop lands in the same cycle
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Entry storage: flush marks every slot dropped; a same-cycle push is born dropped
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_flush) begin
        for (int i = 0; i < DEPTH; i++) r_mem[i].drop <= 1'b1;
      end
      if (w_push) r_mem[r_wr] <= '{drop: i_flush, id: i_push_id};
    end
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// rtl/lsu_mem_arbiter.sv - two-lane lsu arbiter onto a single MMU data port
module lsu_mem_arbiter
  import lsu_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_flush,
  lsu_mem_arbiter_if.slave   io_bus
);

  logic       r_lock;
  logic       r_lock_id;
  logic       w_gnt;
  logic       w_mmu_req;
  logic       w_push;
  logic       w_pop;
  logic       w_stall;
  logic       w_full;
  logic       w_empty;
  arb_entry_t w_head;
  mem_req_t   w_sel;

  // Grant: a stalled request keeps the port; otherwise the older lane wins
  always_comb begin
    w_gnt = r_lock ? r_lock_id : !io_bus.rq_req[0];
  end

  // Request mux onto the MMU, zero-cycle
  always_comb begin
    w_sel.addr  = io_bus.rq_addr[w_gnt];
    w_sel.we    = io_bus.rq_we[w_gnt];
    w_sel.size  = io_bus.rq_size[w_gnt];
    w_sel.wstrb = io_bus.rq_wstrb[w_gnt];
    w_sel.wdata = io_bus.rq_wdata[w_gnt];
  end

  assign w_mmu_req = i_reset && io_bus.rq_req[w_gnt] && !w_full;
  assign w_push    = w_mmu_req && io_bus.mmu_addr_ok;
  assign w_stall   = w_mmu_req && !io_bus.mmu_addr_ok && !i_flush;
  assign w_pop     = i_reset && io_bus.mmu_data_ok && !w_empty;

  assign io_bus.mmu_req   = w_mmu_req;
  assign io_bus.mmu_addr  = w_sel.addr;
  assign io_bus.mmu_we    = w_sel.we;
  assign io_bus.mmu_size  = w_sel.size;
  assign io_bus.mmu_wstrb = w_sel.wstrb;
  assign io_bus.mmu_wdata = w_sel.wdata;
  assign io_bus.rq_rdata  = io_bus.mmu_rdata;

  // Accept goes only to the granted port
  always_comb begin
    io_bus.rq_addr_ok = 2'b00;
    if (w_push) io_bus.rq_addr_ok[w_gnt] = 1'b1;
  end

  // Response demux by FIFO head; flushed entries are swallowed
  always_comb begin
    io_bus.rq_data_ok = 2'b00;
    if (w_pop && !w_head.drop) io_bus.rq_data_ok[w_head.id] = 1'b1;
  end

  // Hold the grant while the MMU has not yet taken the request
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_lock    <= 1'b0;
      r_lock_id <= 1'b0;
    end else begin
      r_lock <= w_stall;
      if (w_stall) r_lock_id <= w_gnt;
    end
  end

  lsu_mem_arbiter_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_push    (w_push),
    .i_push_id (w_gnt),
    .i_pop     (w_pop),
    .i_flush   (i_flush),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_head    (w_head)
  );

  // A response with nothing outstanding means the MMU broke ordering
  a_no_orphan_data_ok: assert property (
    @(posedge i_clk) disable iff (!i_reset) !(io_bus.mmu_data_ok && w_empty)
  );

endmodule
